// File: rtl/enigma_pkg.sv
// Shared constants, FSM encoding and wrap-aware position helpers for the Enigma rotor datapath.
package enigma_pkg;
    localparam int POS_W   = 5;
    localparam int NUM_POS = 26;

    localparam int NOTCH_I   = 16;
    localparam int NOTCH_II  = 4;
    localparam int NOTCH_III = 21;
    localparam int NOTCH_IV  = 9;
    localparam int NOTCH_V   = 25;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    typedef enum logic [1:0] {IDLE, STEP, DONE} step_state_e;

    // Wrap at the alphabet size, never at the 5-bit boundary.
    function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p,
                                                 input logic [POS_W-1:0] last);
        return (p >= last) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [POS_W-1:0] pos_dec(input logic [POS_W-1:0] p,
                                                 input logic [POS_W-1:0] last);
        return (p == '0) ? last : p - 1'b1;
    endfunction
endpackage

// File: rtl/rotor_pos_next.sv
// Next rotor positions for one forward step (with optional double-step) or one odometer-style reverse.
module rotor_pos_next
    import enigma_pkg::*;
#(
    parameter int NUM_POS_P = 26
) (
    input  logic [POS_W-1:0] r1,
    input  logic [POS_W-1:0] r2,
    input  logic [POS_W-1:0] r3,
    input  logic             dir,
    input  logic [POS_W-1:0] notch2,
    input  logic [POS_W-1:0] notch3,
    input  logic             double_step,
    output logic [POS_W-1:0] r1_next,
    output logic [POS_W-1:0] r2_next,
    output logic [POS_W-1:0] r3_next
);
    localparam logic [POS_W-1:0] LAST = POS_W'(NUM_POS_P - 1);

    logic [POS_W-1:0] r3_back;
    logic [POS_W-1:0] r2_back;
    logic             r2_carry_back;

    assign r3_back       = pos_dec(r3, LAST);
    assign r2_carry_back = (r3_back == notch3);
    assign r2_back       = r2_carry_back ? pos_dec(r2, LAST) : r2;

    always_comb begin
        r1_next = r1;
        r2_next = r2;
        r3_next = r3;
        if (dir == DIR_FWD) begin
            r3_next = pos_inc(r3, LAST);
            if ((r3 == notch3) || (double_step && (r2 == notch2)))
                r2_next = pos_inc(r2, LAST);
            if (r2 == notch2)
                r1_next = pos_inc(r1, LAST);
        end else begin
            // Reverse never undoes a double-step; it only unwinds true carries.
            r3_next = r3_back;
            r2_next = r2_back;
            if (r2_carry_back && (r2_back == notch2))
                r1_next = pos_dec(r1, LAST);
        end
    end
endmodule

// File: rtl/rotor_step_scheduler.sv
// Owns the r1/r2/r3 rotor positions; applies load and handshaked step requests through IDLE/STEP/DONE.
module rotor_step_scheduler
    import enigma_pkg::*;
#(
    parameter int NUM_POS     = 26,
    parameter int NOTCH1      = NOTCH_I,
    parameter int NOTCH2      = NOTCH_II,
    parameter int NOTCH3      = NOTCH_III,
    parameter bit DOUBLE_STEP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [POS_W-1:0] r1_init,
    input  logic [POS_W-1:0] r2_init,
    input  logic [POS_W-1:0] r3_init,
    input  logic             step_valid,
    input  logic             step_dir,
    output logic             step_ready,
    output logic             step_done,
    output logic             busy,
    output logic [POS_W-1:0] r1_pos,
    output logic [POS_W-1:0] r2_pos,
    output logic [POS_W-1:0] r3_pos,
    output logic             cfg_err
);
    localparam logic [POS_W-1:0] NPOS = POS_W'(NUM_POS);

    // r1 has no successor rotor, so NOTCH1 only needs to be a legal position.
    if (NOTCH1 >= NUM_POS || NOTCH2 >= NUM_POS || NOTCH3 >= NUM_POS) begin : g_bad_notch
        $error("rotor_step_scheduler: notch parameter out of range");
    end

    step_state_e      state, state_nxt;
    logic             dir_q;
    logic             accept;
    logic             load_ok;
    logic [POS_W-1:0] r1_nxt, r2_nxt, r3_nxt;

    assign step_ready = (state == IDLE) && !load;
    assign accept     = step_valid && step_ready;
    assign step_done  = (state == DONE);
    assign busy       = (state != IDLE);
    assign load_ok    = (r1_init < NPOS) && (r2_init < NPOS) && (r3_init < NPOS);

    rotor_pos_next #(.NUM_POS_P(NUM_POS)) u_next (
        .r1          (r1_pos),
        .r2          (r2_pos),
        .r3          (r3_pos),
        .dir         (dir_q),
        .notch2      (POS_W'(NOTCH2)),
        .notch3      (POS_W'(NOTCH3)),
        .double_step (DOUBLE_STEP),
        .r1_next     (r1_nxt),
        .r2_next     (r2_nxt),
        .r3_next     (r3_nxt)
    );

    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = STEP;
                STEP:    state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            dir_q   <= DIR_FWD;
            r1_pos  <= '0;
            r2_pos  <= '0;
            r3_pos  <= '0;
            cfg_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept)
                dir_q <= step_dir;
            if (load) begin
                cfg_err <= !load_ok;
                if (load_ok) begin
                    r1_pos <= r1_init;
                    r2_pos <= r2_init;
                    r3_pos <= r3_init;
                end
            end else if (state == STEP) begin
                r1_pos <= r1_nxt;
                r2_pos <= r2_nxt;
                r3_pos <= r3_nxt;
            end
        end
    end
endmodule
